// File: rtl/stop_watch_pkg.sv
// stop_watch_pkg: shared state encoding, button indices, lap record layout and BCD limits
package stop_watch_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_OVF} state_t;
  localparam int BTN_START = 0;
  localparam int BTN_LAP = 1;
  localparam int BTN_CLR = 2;
  localparam int BTN_VIEW = 3;
  localparam logic [3:0] BCD_MAX_DEC = 4'd9;
  localparam logic [3:0] BCD_MAX_SEX = 4'd5;
  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
  } lap_t;
  localparam lap_t TIME_MAX = 24'h995999;
  function automatic logic [3:0] digit_max(input int i);
    return i == 3 ? BCD_MAX_SEX : BCD_MAX_DEC;
  endfunction
endpackage

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: MM:SS.cc BCD chain advancing one centisecond per tick, holding at 99:59.99
module bcd_time_counter
  import stop_watch_pkg::*;
(
  input  logic clk,
  input  logic reset_p,
  input  logic tick,
  input  logic clear,
  output lap_t value,
  output logic term
);
  logic [5:0] at_max;
  logic [6:0] carry;
  logic [23:0] nxt;
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < 6; i++) begin : g_dig
    assign at_max[i] = value[4*i +: 4] == digit_max(i);
    assign carry[i+1] = carry[i] && at_max[i];
    assign nxt[4*i +: 4] = !carry[i] ? value[4*i +: 4] : at_max[i] ? 4'd0 : value[4*i +: 4] + 4'd1;
  end
  assign term = carry[6];
  // Advance on tick unless every digit already sits at its limit; clear returns to 00:00.00
  always_ff @(posedge clk)
    if (reset_p || clear) value <= '0;
    else if (tick && !term) value <= nxt;
endmodule

// File: rtl/stop_watch_lap_core.sv
// stop_watch_lap_core: prescaled BCD stopwatch with FSM, circular lap buffer and browse view
module stop_watch_lap_core
  import stop_watch_pkg::*;
#(
  parameter int TICK_DIV = 1_250_000,
  parameter int LAP_DEPTH = 4,
  localparam int CW = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic [3:0]    btn,
  output logic [15:0]   time_digit,
  output logic [7:0]    min_digit,
  output logic          running,
  output logic          ovf,
  output logic [CW-1:0] lap_count,
  output logic [CW-1:0] view_idx
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int MW = 1 << CW;
  state_t state, state_nxt;
  logic [PW-1:0] presc;
  logic [CW-1:0] wr_ptr, lap_cnt, view, rd_ptr;
  lap_t lap_mem [MW];
  lap_t live, shown;
  logic in_run, tick, term, clr, cap;
  bcd_time_counter u_cnt (
    .clk(clk),
    .reset_p(reset_p),
    .tick(tick),
    .clear(clr),
    .value(live),
    .term(term)
  );
  assign rd_ptr = wr_ptr >= view ? wr_ptr - view : wr_ptr + CW'(LAP_DEPTH) - view;
  assign shown = view == '0 ? live : lap_mem[rd_ptr];
  // State register
  always_ff @(posedge clk)
    if (reset_p) state <= S_IDLE;
    else state <= state_nxt;
  // Next state; overflow wins over a same-cycle stop in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = btn[BTN_START] ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = tick && term ? S_OVF : btn[BTN_START] ? S_PAUSE : S_RUN;
      S_PAUSE: state_nxt = clr ? S_IDLE : btn[BTN_START] ? S_RUN : S_PAUSE;
      default: state_nxt = clr ? S_IDLE : S_OVF;
    endcase
  end
  // Control decode: tick, legal clear and lap capture
  always_comb begin
    in_run = state == S_RUN;
    tick = in_run && presc == PW'(TICK_DIV - 1);
    clr = btn[BTN_CLR] && (state == S_PAUSE || state == S_OVF);
    cap = in_run && btn[BTN_LAP];
  end
  // Prescaler runs only in RUN and is held (not cleared) across PAUSE
  always_ff @(posedge clk)
    if (reset_p || clr) presc <= '0;
    else if (in_run) presc <= tick ? '0 : presc + PW'(1);
  // Lap buffer and browse index; capture records the pre-tick value and snaps view to live
  always_ff @(posedge clk)
    if (reset_p || clr) begin
      wr_ptr <= '0;
      lap_cnt <= '0;
      view <= '0;
      for (int k = 0; k < MW; k++) lap_mem[k] <= '0;
    end else if (cap) begin
      lap_mem[wr_ptr] <= live;
      wr_ptr <= wr_ptr == CW'(LAP_DEPTH - 1) ? '0 : wr_ptr + CW'(1);
      lap_cnt <= lap_cnt == CW'(LAP_DEPTH) ? lap_cnt : lap_cnt + CW'(1);
      view <= '0;
    end else if (btn[BTN_VIEW]) view <= view == lap_cnt ? '0 : view + CW'(1);
  // Registered outputs trail internal state by one cycle
  always_ff @(posedge clk)
    if (reset_p) begin
      {min_digit, time_digit} <= '0;
      running <= 1'b0;
      ovf <= 1'b0;
      lap_count <= '0;
      view_idx <= '0;
    end else begin
      {min_digit, time_digit} <= shown;
      running <= in_run;
      ovf <= state == S_OVF;
      lap_count <= lap_cnt;
      view_idx <= view;
    end
endmodule

// File: doc/stop_watch_lap_core.md
Name: stop_watch_lap_core

Overview:
Parametrised successor to the single-lap stopwatch core.
- Counts MM:SS.cc in BCD from a prescaled system clock.
- Provides start/pause/resume, a circular lap buffer of LAP_DEPTH entries with a browse view, and an overflow stop at 99:59.99.
- Sits between the button edge-detect/debounce stage and the FND/7-segment display driver.

Parameters:
TICK_DIV, 1_250_000, clk cycles per centisecond tick (125 MHz / 100); benches use 4.
LAP_DEPTH, 4, number of stored laps (>=1).
CW, $clog2(LAP_DEPTH+1), width of lap_count/view_idx (localparam, derived).

Ports:
clk  in  1  system clock; single clock domain, all logic on rising edge
reset_p  in  1  synchronous, active-high reset
btn  in  4  one-cycle pulses from edge detector: [0] start/stop, [1] lap, [2] clear, [3] view next
time_digit  out  16  {sec_tens, sec_ones, cs_tens, cs_ones} BCD of selected source
min_digit  out  8  {min_tens, min_ones} BCD of selected source
running  out  1  1 while in RUN
ovf  out  1  sticky overflow flag
lap_count  out  CW  stored laps, saturates at LAP_DEPTH
view_idx  out  CW  0 = live, k = k-th most recent lap

Behaviour:
- Reset (reset_p=1 at a clk edge): state IDLE, counters/prescaler/laps zero, wr_ptr=0. All outputs 0 from the following cycle.
- FSM states IDLE, RUN, PAUSE, OVF:
  - IDLE: btn0 -> RUN.
  - RUN: btn0 -> PAUSE; terminal tick -> OVF.
  - PAUSE: btn0 -> RUN; btn2 -> IDLE.
  - OVF: btn2 -> IDLE; btn0 ignored.
  - btn2 in RUN or IDLE: ignored; IDLE is already clear.
- Prescaler counts 0..TICK_DIV-1 only in RUN. tick = (prescaler==TICK_DIV-1), after which it wraps to 0.
  - PAUSE holds the prescaler; it is not cleared, so the sub-tick fraction is preserved.
  - Clear/reset zero it.
- BCD chain advances by one centisecond on tick:
  - cs_ones 0-9 -> cs_tens 0-9 -> sec_ones 0-9 -> sec_tens 0-5 -> min_ones 0-9 -> min_tens 0-9.
  - Each digit wraps to 0 and carries.
  - Tick at 99:59.99: counter holds 99:59.99, ovf=1, state OVF, running=0. No wrap.
- Lap capture: btn1 in RUN only.
  - Writes the 24-bit {min, sec, cs} value as it stands before any same-cycle tick to lap_mem[wr_ptr].
  - wr_ptr increments mod LAP_DEPTH. When full, the oldest entry is overwritten.
  - lap_count increments, saturating at LAP_DEPTH.
  - Capture forces view_idx=0.
  - btn1 in IDLE/PAUSE/OVF is ignored.
- View: btn3 sets view_idx = (view_idx==lap_count) ? 0 : view_idx+1. With lap_count=0, view_idx stays 0.
  - Lap k is read from lap_mem[(wr_ptr-k) mod LAP_DEPTH].
- Clear (PAUSE/OVF + btn2): counters, prescaler, ovf, lap_mem valid state, lap_count, wr_ptr and view_idx all zero; state IDLE.
- Same-cycle priority:
  1. Legal btn2 overrides all other buttons.
  2. btn0 together with btn1 in RUN: lap captured and state -> PAUSE.
  3. btn3 is ignored in a cycle that captures or clears.
- Latency:
  - time_digit/min_digit/running/ovf/lap_count/view_idx are registered.
  - They reflect state/counter updates one cycle after the causing edge. Example: btn0 sampled at edge N gives running=1 after edge N+1.
- Reset mid-RUN or with laps stored has the same effect as power-up reset.

Decomposition:
- Package stop_watch_pkg holds:
  - state encoding (IDLE/RUN/PAUSE/OVF)
  - button index constants (BTN_START=0, BTN_LAP=1, BTN_CLR=2, BTN_VIEW=3)
  - 24-bit lap record layout
  - BCD terminal constants (9, 5, 99:59.99)
- One sub-module, bcd_time_counter: takes tick and clear; outputs the six BCD digits and a terminal flag.
- Top level holds the prescaler, FSM, lap memory and view mux.

Test Plan:
All scenarios use TICK_DIV=4, LAP_DEPTH=4.
1. Reset, btn0 pulse, wait 400 clk -> time_digit=16'h0100, min_digit=0, running=1.
2. Pause at 16'h0123 with prescaler=2, idle 1000 clk -> time_digit unchanged; btn0 -> first increment to 16'h0124 exactly 2 clk later.
3. Laps at 00.05, 00.10, 00.15, 00.20, 00.25 -> lap_count=4. btn3 ×5 -> view shows 0025, 0020, 0015, 0010, then live (view_idx 0); 0005 has been overwritten.
4. Run 2,400,000 clk -> min_digit=8'h99, time_digit=16'h5999, ovf=1, running=0. btn0 has no effect; btn2 -> all outputs 0, state IDLE.
5. btn2 in RUN ignored (count continues). btn0 and btn1 in the same cycle -> lap equals the displayed value and running=0.
6. reset_p asserted mid-RUN with 3 laps stored -> next cycle all outputs 0. A following btn0 starts from 00:00.00.
